// File: rtl/spectrum_frame_buffer_if.sv
// spectrum_frame_buffer_if: FFT modulus input stream and valid/ready replay stream
interface spectrum_frame_buffer_if #(
  parameter int IN_W   = 32,
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 8
);
  logic [IN_W-1:0]   data_modulus;
  logic              data_sop;
  logic              data_eop;
  logic              data_valid;
  logic              out_ready;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic [ADDR_W-1:0] out_bin;
  logic              out_sop;
  logic              out_eop;
  modport master (
    output data_modulus, data_sop, data_eop, data_valid, out_ready,
    input  out_valid, out_data, out_bin, out_sop, out_eop
  );
  modport slave (
    input  data_modulus, data_sop, data_eop, data_valid, out_ready,
    output out_valid, out_data, out_bin, out_sop, out_eop
  );
endinterface

// File: rtl/spectrum_frame_buffer.sv
// spectrum_frame_buffer: ping-pong capture of FFT modulus frames with scaling, peak tracking and replay
module spectrum_frame_buffer #(
  parameter int FFT_N  = 256,
  parameter int ADDR_W = 8,
  parameter int IN_W   = 32,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 8
) (
  input  logic                  clk_50m,
  input  logic                  rst_n,
  spectrum_frame_buffer_if.slave s,
  input  logic                  rd_req,
  output logic                  frame_avail,
  output logic [ADDR_W-1:0]     peak_bin,
  output logic [IN_W-1:0]       peak_val,
  output logic                  peak_valid,
  output logic                  frame_err,
  output logic                  frame_drop
);
  typedef enum logic {C_IDLE, C_FILL} c_state_t;
  typedef enum logic [1:0] {R_IDLE, R_RD, R_OUT} r_state_t;
  c_state_t c_state, c_state_n;
  r_state_t r_state, r_state_n;
  logic [ADDR_W-1:0] cnt, cnt_n, wa, rd_addr, rd_addr_n, run_bin, run_bin_n;
  logic [IN_W-1:0] run_val, run_val_n, shifted;
  logic [OUT_W-1:0] scaled, ram_q;
  logic [OUT_W-1:0] mem [2*FFT_N];
  logic [1:0] full, full_n;
  logic wr_bank, wr_bank_n, wb, swap, latest, latest_n, rd_bank, rd_bank_n;
  logic we, commit, drop, err, first, last, gt, r_start, out_v;

  assign shifted = s.data_modulus >> SHIFT;
  assign scaled  = |shifted[IN_W-1:OUT_W] ? '1 : shifted[OUT_W-1:0];
  assign first   = s.data_valid && s.data_sop;
  assign last    = cnt == ADDR_W'(FFT_N-1);
  assign gt      = s.data_modulus > run_val;
  assign r_start = r_state == R_IDLE && rd_req && full[latest];
  // a reader grabbing the bank the writer points at pushes the writer onto the other bank
  assign swap      = r_start && latest == wr_bank;
  assign wb        = wr_bank ^ swap;
  assign wr_bank_n = commit && r_state == R_IDLE && !r_start ? ~wb : wb;
  assign latest_n  = commit ? wb : latest;
  assign frame_avail = full[latest];

  // capture FSM: bin addressing, peak tracking, commit/discard decisions
  always_comb begin
    c_state_n = c_state;
    cnt_n = cnt;
    run_val_n = run_val;
    run_bin_n = run_bin;
    we = 1'b0;
    wa = cnt;
    commit = 1'b0;
    drop = 1'b0;
    err = 1'b0;
    if (first) begin
      we = 1'b1;
      wa = '0;
      cnt_n = ADDR_W'(1);
      c_state_n = C_FILL;
      run_val_n = s.data_modulus;
      run_bin_n = '0;
      drop = c_state == C_IDLE && full[wb];
      err = c_state == C_FILL;
    end else if (c_state == C_FILL && s.data_valid && (last || !s.data_eop)) begin
      we = 1'b1;
      cnt_n = cnt + 1'b1;
      run_val_n = gt ? s.data_modulus : run_val;
      run_bin_n = gt ? cnt : run_bin;
      commit = last;
      c_state_n = last ? C_IDLE : C_FILL;
    end else if (c_state == C_FILL && s.data_eop) begin
      err = 1'b1;
      c_state_n = C_IDLE;
    end
  end

  // full flags: reader claims a frame, a new frame start overwrites, a commit publishes
  always_comb begin
    full_n = full;
    if (r_start) full_n[latest] = 1'b0;
    if (drop) full_n[wb] = 1'b0;
    if (commit) full_n[wb] = 1'b1;
  end

  // capture and bank bookkeeping registers
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      c_state <= C_IDLE;
      cnt <= '0;
      run_val <= '0;
      run_bin <= '0;
      wr_bank <= 1'b0;
      latest <= 1'b0;
      full <= '0;
      peak_bin <= '0;
      peak_val <= '0;
      peak_valid <= 1'b0;
      frame_err <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      c_state <= c_state_n;
      cnt <= cnt_n;
      run_val <= run_val_n;
      run_bin <= run_bin_n;
      wr_bank <= wr_bank_n;
      latest <= latest_n;
      full <= full_n;
      peak_bin <= commit ? run_bin_n : peak_bin;
      peak_val <= commit ? run_val_n : peak_val;
      peak_valid <= commit;
      frame_err <= err;
      frame_drop <= drop;
    end
  end

  // read FSM: one RAM read per bin, then hold the bin until the sink takes it
  always_comb begin
    r_state_n = r_state;
    rd_addr_n = rd_addr;
    rd_bank_n = rd_bank;
    if (r_start) begin
      r_state_n = R_RD;
      rd_addr_n = '0;
      rd_bank_n = latest;
    end else if (r_state == R_RD) begin
      r_state_n = R_OUT;
    end else if (r_state == R_OUT && s.out_ready) begin
      r_state_n = last_rd() ? R_IDLE : R_RD;
      rd_addr_n = rd_addr + 1'b1;
    end
  end

  function automatic logic last_rd();
    return rd_addr == ADDR_W'(FFT_N-1);
  endfunction

  // read FSM state register
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      rd_addr <= '0;
      rd_bank <= 1'b0;
    end else begin
      r_state <= r_state_n;
      rd_addr <= rd_addr_n;
      rd_bank <= rd_bank_n;
    end
  end

  // dual-bank frame RAM with registered read
  always_ff @(posedge clk_50m) begin
    if (rst_n && we) mem[{wb, wa}] <= scaled;
    if (r_state == R_RD) ram_q <= mem[{rd_bank, rd_addr}];
  end

  assign out_v       = r_state == R_OUT;
  assign s.out_valid = out_v;
  assign s.out_data  = out_v ? ram_q : '0;
  assign s.out_bin   = out_v ? rd_addr : '0;
  assign s.out_sop   = out_v && rd_addr == '0;
  assign s.out_eop   = out_v && last_rd();
endmodule
